// File: rtl/traffic_controller_timed.sv
// traffic_controller_timed
//
// Highway / country-road intersection controller. A six-phase FSM drives the
// lamp outputs, and a down-counting phase timer sets each phase's dwell:
// minimum highway green, yellow, all-red clearance and maximum country green.
// Lamp encoding: 0 red, 1 yellow, 2 green.
//
// Optional feature: define TRAFFIC_PED_EN to compile in the pedestrian
// crossing (ped_req input, walk output, pending/served flags).
//
// Ports:
//   clock    in   rising-edge clock
//   clear_n  in   synchronous active-low reset
//   vehicle  in   country-road vehicle present
//   ped_req  in   pedestrian button pulse (TRAFFIC_PED_EN only)
//   HW       out  highway lamp
//   CR       out  country-road lamp
//   phase    out  current FSM state code (debug)
//   walk     out  walk lamp (TRAFFIC_PED_EN only)

module traffic_controller_timed #(
    parameter int unsigned MIN_HW_GREEN  = 8,
    parameter int unsigned MAX_CR_GREEN  = 16,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned ALLRED_CYCLES = 2,
    parameter int unsigned TIMER_W       = 8
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       vehicle,
`ifdef TRAFFIC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] HW,
    output logic [1:0] CR,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StHg  = 3'd0,
        StHy  = 3'd1,
        StAr1 = 3'd2,
        StCg  = 3'd3,
        StCy  = 3'd4,
        StAr2 = 3'd5
    } state_e;

    localparam logic [1:0] LampRed    = 2'd0;
    localparam logic [1:0] LampYellow = 2'd1;
    localparam logic [1:0] LampGreen  = 2'd2;

    // Timer load values are dwell-1 so a phase of dwell N spans N cycles.
    localparam logic [TIMER_W-1:0] HgLoad = TIMER_W'(MIN_HW_GREEN - 1);
    localparam logic [TIMER_W-1:0] CgLoad = TIMER_W'(MAX_CR_GREEN - 1);
    localparam logic [TIMER_W-1:0] YLoad  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ArLoad = TIMER_W'(ALLRED_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timer_done;
    logic               request;
    logic               cg_hold;

    function automatic logic [TIMER_W-1:0] dwell_load(input state_e s);
        case (s)
            StHy, StCy:   dwell_load = YLoad;
            StAr1, StAr2: dwell_load = ArLoad;
            StCg:         dwell_load = CgLoad;
            default:      dwell_load = HgLoad;
        endcase
    endfunction

`ifdef TRAFFIC_PED_EN
    logic ped_pending_q, ped_pending_d;
    logic ped_served_q, ped_served_d;
    logic cg_entry;

    assign request = vehicle | ped_pending_q;
    // A ped-served CG runs its full maximum regardless of traffic.
    assign cg_hold = ped_served_q;
    assign cg_entry = (state_d == StCg) && (state_q != StCg);

    always_comb begin
        ped_pending_d = ped_pending_q | ped_req;
        ped_served_d  = ped_served_q;
        if (cg_entry) begin
            // A request landing on the entry edge is absorbed into this service.
            ped_pending_d = 1'b0;
            ped_served_d  = ped_pending_q | ped_req;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            ped_pending_q <= 1'b0;
            ped_served_q  <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            ped_served_q  <= ped_served_d;
        end
    end

    assign walk = (state_q == StCg) && ped_served_q;
`else
    assign request = vehicle;
    assign cg_hold = 1'b0;
`endif

    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHg:  if (timer_done && request) state_d = StHy;
            StHy:  if (timer_done) state_d = StAr1;
            StAr1: if (timer_done) state_d = StCg;
            StCg:  if (timer_done || (!vehicle && !cg_hold)) state_d = StCy;
            StCy:  if (timer_done) state_d = StAr2;
            StAr2: if (timer_done) state_d = StHg;
            default: state_d = StHg;  // illegal codes recover to HG
        endcase

        if (state_d != state_q) begin
            timer_d = dwell_load(state_d);
        end else if (timer_done) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= StHg;
            timer_q <= HgLoad;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        HW = LampRed;
        CR = LampRed;
        case (state_q)
            StHg:    HW = LampGreen;
            StHy:    HW = LampYellow;
            StCg:    CR = LampGreen;
            StCy:    CR = LampYellow;
            default: ;
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_controller_timed.sv
// Scoreboard bench for traffic_controller_timed. The driver applies one input
// vector per cycle, advances a phase/age reference model and queues the
// expected lamp/phase/walk outputs; the monitor pops and compares each cycle.

module tb_traffic_controller_timed;

    localparam int MinHw  = 8;
    localparam int MaxCr  = 16;
    localparam int Yel    = 3;
    localparam int AllRed = 2;

    typedef struct packed {
        logic [1:0] hw;
        logic [1:0] cr;
        logic [2:0] ph;
        logic       wk;
    } obs_t;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       vehicle;
    logic [1:0] hw;
    logic [1:0] cr;
    logic [2:0] phase;
    logic       walk;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: phase index 0..5 and cycles spent in the phase so far.
    int   dwell[6] = '{MinHw, Yel, AllRed, MaxCr, Yel, AllRed};
    int   m_phase = 0;
    int   m_age = 1;
    bit   m_pend = 1'b0;
    bit   m_served = 1'b0;

    always #5 clock = ~clock;

`ifdef TRAFFIC_PED_EN
    logic ped_req;

    traffic_controller_timed dut (
        .clock   (clock),
        .clear_n (clear_n),
        .vehicle (vehicle),
        .ped_req (ped_req),
        .walk    (walk),
        .HW      (hw),
        .CR      (cr),
        .phase   (phase)
    );
    localparam bit PedEn = 1'b1;
`else
    traffic_controller_timed dut (
        .clock   (clock),
        .clear_n (clear_n),
        .vehicle (vehicle),
        .HW      (hw),
        .CR      (cr),
        .phase   (phase)
    );
    assign walk = 1'b0;
    localparam bit PedEn = 1'b0;
`endif

    function automatic obs_t model_obs();
        obs_t o;
        o.hw = (m_phase == 0) ? 2'd2 : (m_phase == 1) ? 2'd1 : 2'd0;
        o.cr = (m_phase == 3) ? 2'd2 : (m_phase == 4) ? 2'd1 : 2'd0;
        o.ph = 3'(m_phase);
        o.wk = (m_phase == 3) && m_served;
        return o;
    endfunction

    task automatic step(input bit rst_n, input bit veh, input bit ped);
        bit leave;
        @(negedge clock);
        clear_n = rst_n;
        vehicle = veh;
`ifdef TRAFFIC_PED_EN
        ped_req = ped;
`endif
        if (!rst_n) begin
            m_phase  = 0;
            m_age    = 1;
            m_pend   = 1'b0;
            m_served = 1'b0;
        end else begin
            case (m_phase)
                0:       leave = (m_age >= MinHw) && (veh || m_pend);
                3:       leave = (m_age >= MaxCr) || (!m_served && !veh);
                default: leave = (m_age >= dwell[m_phase]);
            endcase
            if (leave && m_phase == 2) begin
                m_served = m_pend || ped;
                m_pend   = 1'b0;
            end else begin
                m_pend = m_pend || ped;
            end
            if (leave) begin
                m_phase = (m_phase + 1) % 6;
                m_age   = 1;
            end else begin
                m_age++;
            end
        end
        exp_q.push_back(model_obs());
    endtask

    // Monitor: one output observation per clock, sampled just after the edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hw, cr, phase, walk};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t: got HW=%0d CR=%0d phase=%0d walk=%0d, expected HW=%0d CR=%0d phase=%0d walk=%0d",
                             vectors, $time, a.hw, a.cr, a.ph, a.wk, e.hw, e.cr, e.ph, e.wk);
                end
            end
        end
    end

    initial begin
        int tgt[2] = '{2, 4};
        int p;
        clear_n = 1'b0;
        vehicle = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif
        // Reset, then an idle country road: HG must hold.
        step(0, 0, 0);
        step(0, 0, 0);
        repeat (50) step(1, 0, 0);

        // Vehicle held from reset release: full 34-cycle periods.
        step(0, 0, 0);
        repeat (80) step(1, 1, 0);

        // Reset mid-AR1 and mid-CY; HG minimum must restart afterwards.
        foreach (tgt[i]) begin
            step(0, 1, 0);
            for (int n = 0; n < 100 && m_phase != tgt[i]; n++) step(1, 1, 0);
            step(0, 1, 0);
            repeat (12) step(1, 1, 0);
        end

        // Vehicle leaves on CG cycle 5.
        step(0, 1, 0);
        for (int n = 0; n < 100 && !(m_phase == 3 && m_age == 5); n++) step(1, 1, 0);
        repeat (12) step(1, 0, 0);

        // Short vehicle pulse in HG before the minimum elapses.
        step(0, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        repeat (10) step(1, 0, 0);
        step(1, 1, 0);
        repeat (5) step(1, 0, 0);

        if (PedEn) begin
            // Pedestrian pulse, then a second pulse on the CG-entry edge.
            step(0, 0, 0);
            step(1, 0, 1);
            for (int n = 0; n < 100 && !(m_phase == 2 && m_age == 2); n++) step(1, 0, 0);
            step(1, 0, 1);
            repeat (60) step(1, 0, 0);
        end

        // Randomized traffic with varying vehicle density and sparse resets.
        for (int blk = 0; blk < 15; blk++) begin
            p = $urandom_range(0, 100);
            repeat (100) begin
                step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < p,
                     PedEn && ($urandom_range(0, 39) == 0));
            end
        end

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
